gray_frame_sched: RTL

- Frame-level sequencer in front of the RGB565-to-gray pipeline (3-cycle latency) in the OV5640 capture path.
- Admits only whole frames into the converter and latches the gray/bypass mode only at frame start.
- Checks frame length, then waits out the converter latency before signalling frame completion.

---
 rtl/gray_frame_sched.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/gray_frame_sched.sv
// ============================================================================
// Module   : gray_frame_sched
// Brief    : Whole-frame admission, length check and drain sequencer ahead of
//            the RGB565-to-gray converter. Optional macro: GRAY_FRAME_SKIP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_frame_sched #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int PIPE_LAT = 3,
    parameter int CNT_W    = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_en,
    input  logic        cfg_gray,
`ifdef GRAY_FRAME_SKIP_EN
    input  logic [1:0]  cfg_skip,
`endif
    input  logic [15:0] din,
    input  logic        din_vld,
    input  logic        din_sop,
    input  logic        din_eop,
    output logic [15:0] pix_out,
    output logic        pix_vld,
    output logic        pix_sop,
    output logic        pix_eop,
    output logic        mode_gray,
    output logic        busy,
    output logic        frame_done,
    output logic        err_len,
    output logic [15:0] frame_cnt
);

    localparam logic [CNT_W-1:0] c_FRAME    = CNT_W'(IMG_W * IMG_H);
    localparam logic [CNT_W-1:0] c_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]       c_DRN_LAST = 3'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOP = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_drn;
    logic               r_frame_fwd;

    // One-entry elastic stage: absorbs the extra cycle created by the
    // truncation marker until an input gap lets the stream catch up.
    logic               r_hold_vld;
    logic [15:0]        r_hold_data;
    logic               r_hold_sop;
    logic               r_hold_eop;

    logic               w_acc;
    logic               w_start;
    logic               w_short;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_cnt_hit;
    logic               w_end;
    logic               w_err;
    logic               w_start_fwd;
    logic               w_new_fwd;
    logic               w_beat_fwd;
    logic               w_drn_done;
    logic               w_mark_case;

    logic               w_o_vld;
    logic               w_o_sop;
    logic               w_o_eop;
    logic [15:0]        w_o_data;
    logic               w_hold_vld_nxt;
    logic [15:0]        w_hold_data_nxt;
    logic               w_hold_sop_nxt;
    logic               w_hold_eop_nxt;

    always_comb begin
        w_acc   = 1'b0;
        w_start = 1'b0;
        case (r_state)
            ST_WAIT_SOP: begin
                w_start = din_vld & din_sop & cfg_en;
                w_acc   = w_start;
            end
            ST_ACTIVE: begin
                w_start = din_vld & din_sop;
                w_acc   = din_vld;
            end
            default: begin
                w_acc   = 1'b0;
                w_start = 1'b0;
            end
        endcase
    end

    assign w_short    = (r_state == ST_ACTIVE) & din_vld & din_sop;
    assign w_cnt_nxt  = w_start ? c_ONE : (r_cnt + c_ONE);
    assign w_cnt_hit  = (w_cnt_nxt == c_FRAME);
    assign w_end      = w_acc & (din_eop | w_cnt_hit);
    assign w_err      = w_end & ~(din_eop & w_cnt_hit);
    assign w_drn_done = (r_state == ST_DRAIN) & ~r_hold_vld & (r_drn == c_DRN_LAST);

`ifdef GRAY_FRAME_SKIP_EN
    logic [1:0] r_skip_cnt;
    logic [1:0] r_skip_mod;
    logic [1:0] w_skip_mod;

    assign w_start_fwd = (r_skip_cnt == 2'd0);
    assign w_skip_mod  = w_start ? cfg_skip : r_skip_mod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip_cnt <= 2'd0;
            r_skip_mod <= 2'd0;
        end else begin
            if (w_start) begin
                r_skip_mod <= cfg_skip;
            end
            if (w_end) begin
                r_skip_cnt <= (r_skip_cnt >= w_skip_mod) ? 2'd0 : (r_skip_cnt + 2'd1);
            end
        end
    end
`else
    assign w_start_fwd = 1'b1;
`endif

    assign w_new_fwd   = w_start ? w_start_fwd : r_frame_fwd;
    assign w_beat_fwd  = w_acc & w_new_fwd;
    assign w_mark_case = w_short & r_frame_fwd;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cfg_en) begin
                    w_state_nxt = ST_WAIT_SOP;
                end
            end
            ST_WAIT_SOP: begin
                if (din_vld && din_sop) begin
                    if (!cfg_en) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_end) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (w_end) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drn_done) begin
                    w_state_nxt = cfg_en ? ST_WAIT_SOP : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_o_vld         = 1'b0;
        w_o_sop         = 1'b0;
        w_o_eop         = 1'b0;
        w_o_data        = pix_out;
        w_hold_vld_nxt  = 1'b0;
        w_hold_data_nxt = r_hold_data;
        w_hold_sop_nxt  = r_hold_sop;
        w_hold_eop_nxt  = r_hold_eop;
        if (w_mark_case) begin
            // A still-held last beat can carry the forced eop itself;
            // otherwise the eop goes out on an empty marker cycle.
            w_o_eop = 1'b1;
            if (r_hold_vld) begin
                w_o_vld  = 1'b1;
                w_o_sop  = r_hold_sop;
                w_o_data = r_hold_data;
            end
            if (w_beat_fwd) begin
                w_hold_vld_nxt  = 1'b1;
                w_hold_data_nxt = din;
                w_hold_sop_nxt  = w_start;
                w_hold_eop_nxt  = w_end;
            end
        end else if (r_hold_vld) begin
            w_o_vld  = 1'b1;
            w_o_sop  = r_hold_sop;
            w_o_eop  = r_hold_eop;
            w_o_data = r_hold_data;
            if (w_beat_fwd) begin
                w_hold_vld_nxt  = 1'b1;
                w_hold_data_nxt = din;
                w_hold_sop_nxt  = w_start;
                w_hold_eop_nxt  = w_end;
            end
        end else if (w_beat_fwd) begin
            w_o_vld  = 1'b1;
            w_o_sop  = w_start;
            w_o_eop  = w_end;
            w_o_data = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_drn       <= 3'd0;
            r_frame_fwd <= 1'b0;
            r_hold_vld  <= 1'b0;
            r_hold_data <= 16'd0;
            r_hold_sop  <= 1'b0;
            r_hold_eop  <= 1'b0;
            pix_out     <= 16'd0;
            pix_vld     <= 1'b0;
            pix_sop     <= 1'b0;
            pix_eop     <= 1'b0;
            mode_gray   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_len     <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_vld  <= w_hold_vld_nxt;
            r_hold_data <= w_hold_data_nxt;
            r_hold_sop  <= w_hold_sop_nxt;
            r_hold_eop  <= w_hold_eop_nxt;
            pix_out     <= w_o_data;
            pix_vld     <= w_o_vld;
            pix_sop     <= w_o_sop;
            pix_eop     <= w_o_eop;
            err_len     <= w_acc & (w_err | w_short);
            frame_done  <= w_drn_done & r_frame_fwd;

            if (w_acc) begin
                r_cnt <= w_cnt_nxt;
            end
            if (w_start) begin
                mode_gray   <= cfg_gray;
                r_frame_fwd <= w_start_fwd;
            end

            if (w_start) begin
                busy <= 1'b1;
            end else if (w_drn_done) begin
                busy <= 1'b0;
            end

            // Latency countdown only starts once the eop has left the hold stage.
            if ((r_state == ST_DRAIN) && !r_hold_vld) begin
                r_drn <= w_drn_done ? 3'd0 : (r_drn + 3'd1);
            end

            if (w_drn_done && r_frame_fwd) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire
